// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe -- two-stage pipelined carry-lookahead adder/subtractor
// with a valid/ready handshake on both sides.
//
// Stage 1 forms the effective operands (B inverted and carry-in inverted
// for subtract). It registers the per-bit propagate and generate terms and
// the per-group (4-bit) propagate/generate, together with the effective
// carry-in.
// Stage 2 forms every group carry-in directly from the stage-1 group terms.
// Each group carry is one sum-of-products, so no carry ripples from one
// group into the next. It then forms the in-group bit carries and
// registers Sum/Cout/Pout/Ovf.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   A, B             operands (WIDTH bits)
//   Cin, Sub         carry/borrow-in; Sub=1 computes A-B-Cin
//   In_valid/ready   input handshake (In_ready depends on Out_ready)
//   Sum, Cout        result; in subtract mode Cout is the inverted borrow
//   Pout             AND of all bit propagates of the effective operands
//   Ovf              two's-complement overflow
//   Out_valid/ready  output handshake

// Per-group operand stage: bit terms plus 4-bit lookahead group terms.
module cla_group (
  input  logic [3:0] a_i,
  input  logic [3:0] be_i,
  output logic [3:0] p_o,
  output logic [2:0] g_o,   // g[3] only feeds the group generate
  output logic       gp_o,
  output logic       gg_o
);
  logic [3:0] g;
  assign p_o  = a_i ^ be_i;
  assign g    = a_i & be_i;
  assign g_o  = g[2:0];
  assign gp_o = &p_o;
  assign gg_o = g[3] | (p_o[3] & g[2]) | (p_o[3] & p_o[2] & g[1]) |
                (p_o[3] & p_o[2] & p_o[1] & g[0]);
endmodule

// Per-group sum stage: in-group bit carries from the group carry-in.
module cla_group_sum (
  input  logic [3:0] p_i,
  input  logic [2:0] g_i,
  input  logic       c_i,
  output logic [3:0] s_o
);
  logic [3:0] c;
  assign c[0] = c_i;
  assign c[1] = g_i[0] | (p_i[0] & c_i);
  assign c[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0]) |
                (p_i[2] & p_i[1] & p_i[0] & c_i);
  assign s_o  = p_i ^ c;
endmodule

module cla_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Pout,
  output logic             Ovf,
  output logic             Out_valid,
  input  logic             Out_ready
);
  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64");
  end

  // Carry into group k. It is written as a flat OR of products, one
  // product per source group, so each group carry is two logic levels
  // deep over the group terms.
  function automatic logic grp_carry(input int k, input logic [NG-1:0] gp,
                                     input logic [NG-1:0] gg, input logic ce);
    logic acc, t;
    acc = ce;
    for (int m = 0; m < k; m++) acc &= gp[m];
    for (int j = 0; j < k; j++) begin
      t = gg[j];
      for (int m = j + 1; m < k; m++) t &= gp[m];
      acc |= t;
    end
    return acc;
  endfunction

  // vld_q[1]: stage-1 occupied, vld_q[2]: Out_valid
  logic [2:1] vld_q;
  logic       ld1, ld2;

  assign ld2       = !vld_q[2] | Out_ready;
  assign ld1       = !vld_q[1] | ld2;
  assign In_ready  = ld1;
  assign Out_valid = vld_q[2];

  // ---- stage 1 ----
  logic [WIDTH-1:0]        be_d;
  logic                    ce_d;
  logic [NG-1:0][3:0]      p_d;
  logic [NG-1:0][2:0]      g_d;
  logic [NG-1:0]           gp_d, gg_d;

  assign be_d = B ^ {WIDTH{Sub}};
  assign ce_d = Cin ^ Sub;

  for (genvar gi = 0; gi < NG; gi++) begin : g_s1
    cla_group u_grp (
      .a_i  (A[gi*4 +: 4]),
      .be_i (be_d[gi*4 +: 4]),
      .p_o  (p_d[gi]),
      .g_o  (g_d[gi]),
      .gp_o (gp_d[gi]),
      .gg_o (gg_d[gi])
    );
  end

  logic [NG-1:0][3:0] p1_q;
  logic [NG-1:0][2:0] g1_q;
  logic [NG-1:0]      gp1_q, gg1_q;
  logic               ce1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q[1] <= 1'b0;
      p1_q     <= '0;
      g1_q     <= '0;
      gp1_q    <= '0;
      gg1_q    <= '0;
      ce1_q    <= 1'b0;
    end else if (ld1) begin
      vld_q[1] <= In_valid;
      if (In_valid) begin
        p1_q  <= p_d;
        g1_q  <= g_d;
        gp1_q <= gp_d;
        gg1_q <= gg_d;
        ce1_q <= ce_d;
      end
    end
  end

  // ---- stage 2 ----
  logic [NG:0]        gc;
  logic [NG-1:0][3:0] s_d;

  assign gc[0] = ce1_q;
  for (genvar k = 1; k <= NG; k++) begin : g_gc
    assign gc[k] = grp_carry(k, gp1_q, gg1_q, ce1_q);
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_s2
    cla_group_sum u_sum (
      .p_i (p1_q[gi]),
      .g_i (g1_q[gi]),
      .c_i (gc[gi]),
      .s_o (s_d[gi])
    );
  end

  logic             cout_d, pout_d, ovf_d, cmsb;
  // carry into the MSB recovered from its sum bit: s = p ^ c
  assign cmsb   = s_d[NG-1][3] ^ p1_q[NG-1][3];
  assign cout_d = gc[NG];
  assign pout_d = &p1_q;
  assign ovf_d  = cmsb ^ cout_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, pout_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q[2] <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      pout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (ld2) begin
      vld_q[2] <= vld_q[1];
      if (vld_q[1]) begin
        sum_q  <= s_d;
        cout_q <= cout_d;
        pout_q <= pout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Pout = pout_q;
  assign Ovf  = ovf_q;
endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 from 4 to 64, and any other value SHALL be a elaboration error.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port A, input, WIDTH, operand A.
REQ-005 SHALL have port B, input, WIDTH, operand B.
REQ-006 SHALL have port Cin, input, 1, carry-in (add) or borrow-in (subtract).
REQ-007 SHALL have port Sub, input, 1: 0 selects add, 1 selects subtract.
REQ-008 SHALL have port In_valid, input, 1, meaning the input operands are valid.
REQ-009 SHALL have port In_ready, output, 1, meaning the block can accept an input this cycle.
REQ-010 SHALL have port Sum, output, WIDTH, result.
REQ-011 SHALL have port Cout, output, 1, carry-out; in subtract mode it is the inverted borrow-out.
REQ-012 SHALL have port Pout, output, 1, AND of all bit-propagate terms of the effective operands.
REQ-013 SHALL have port Ovf, output, 1, two's-complement signed overflow.
REQ-014 SHALL have port Out_valid, output, 1, meaning the result outputs are valid.
REQ-015 SHALL have port Out_ready, input, 1, meaning downstream accepts the result.

Function
REQ-016 Effective operand Be SHALL be B XOR {WIDTH{Sub}}.
REQ-017 Effective carry-in Ce SHALL be Cin XOR Sub, so Sub=1 computes A-B-Cin modulo 2^WIDTH.
REQ-018 Bit terms SHALL be p[i]=A[i]^Be[i] and g[i]=A[i]&Be[i]; groups SHALL be 4 bits, WIDTH/4 groups.
REQ-019 Stage 1 SHALL register per-group P (AND of 4 p) and G (4-bit lookahead generate), all p bits, and Ce.
REQ-020 Stage 2 SHALL compute group carries by lookahead from the stage-1 registers, then per-bit carries and Sum[i]=p[i]^c[i].
REQ-021 Stage 2 SHALL register Sum, Cout, Pout and Ovf; Ovf SHALL be the carry into the MSB XOR Cout.
REQ-022 There SHALL be no ripple chain spanning more than one 4-bit group.
REQ-023 Handshake: a transfer SHALL occur on an edge where valid and ready are both 1, at input and at output.
REQ-024 Stage 2 SHALL load when !Out_valid | Out_ready; stage 1 SHALL load when it is empty or stage 2 loads.
REQ-025 In_ready SHALL equal the stage-1 load condition; In_ready MAY depend combinationally on Out_ready.
REQ-026 Latency SHALL be 2 cycles from an input transfer to Out_valid when not stalled.
REQ-027 Throughput SHALL be 1 result per cycle while Out_ready=1.
REQ-028 Out_valid=1 with Out_ready=0 SHALL hold Sum, Cout, Pout, Ovf and Out_valid stable.
REQ-029 With a full pipeline under stall, In_ready SHALL be 0; no input SHALL be lost or duplicated, and results SHALL leave in input order.
REQ-030 A simultaneous output transfer and input transfer on a full pipeline SHALL advance both stages in the same cycle.
REQ-031 Inputs SHALL be ignored when In_valid=0 or In_ready=0.

Reset
REQ-032 rst_n=0 SHALL immediately clear both stage valid flags, Out_valid, Sum, Cout, Pout and Ovf to 0, independent of clk.
REQ-033 In-flight operations SHALL be discarded on reset; In_ready SHALL be 1 from the first edge after rst_n rises.
REQ-034 Reset deassertion SHALL be synchronised externally; no internal synchroniser SHALL be present.

Verification
REQ-035 WIDTH=16, A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> two cycles later Sum=0x0000, Cout=1, Ovf=0, Pout=0.
REQ-036 WIDTH=16, A=0x7FFF, B=0x0001, Sub=0 -> Sum=0x8000, Ovf=1; A=0x0005, B=0x0007, Sub=1, Cin=0 -> Sum=0xFFFE, Cout=0, Ovf=0.
REQ-037 A=0xAAAA, B=0x5555, Cin=1, Sub=0 -> Pout=1, Sum=0x0000, Cout=1 (full propagate across all groups).
REQ-038 Stream 8 back-to-back inputs, then hold Out_ready=0 for 3 cycles -> In_ready drops after 2 accepted-but-unread items; outputs stay stable; all 8 results appear in order, none lost.
REQ-039 Assert rst_n=0 mid-stream with Out_valid=1 -> Out_valid and Sum go to 0 asynchronously; no pre-reset result appears after release.
REQ-040 WIDTH=4 and WIDTH=64: random operands with all Sub/Cin combinations -> results match a reference model for 10^4 vectors each.
